dma_desc_scheduler: RTL and testbench
=====================================

# dma_desc_scheduler

Shares the XDMA C2H descriptor-bypass port among `NUM_REQ` requesters. Each requester submits one transfer command (host address and byte length). The block arbitrates round-robin between them and splits each accepted command into descriptors that never cross a `MAX_CHUNK` address boundary. It issues those descriptors on the `c2h_dsc_byp_*` handshake of the DMA driver and pulses a per-requester done flag once the last descriptor of a command has been loaded. It sits between the application-side command sources and `dma_driver`, in the `pcie_clk` domain.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `MAX_CHUNK`, default 4096: descriptor size cap and boundary in bytes; must be a power of two, 64..2^27.

Ports:
- `pcie_clk`, in, 1: single clock; every signal is synchronous to it.
- `pcie_aresetn`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, `NUM_REQ`: command pending, one bit per requester.
- `req_ready`, out, `NUM_REQ`: command accepted; one-hot, single-cycle.
- `req_addr`, in, `NUM_REQ*64`: flattened host addresses; requester i uses bits [64i+63:64i].
- `req_len`, in, `NUM_REQ*32`: flattened byte lengths; bits [31:28] of each length are ignored.
- `req_done`, out, `NUM_REQ`: single-cycle pulse for requester i when its last descriptor is loaded.
- `dsc_byp_ready`, in, 1: connects to `c2h_dsc_byp_ready_0`.
- `dsc_byp_addr`, out, 64: descriptor destination address.
- `dsc_byp_len`, out, 32: descriptor length in bytes; always ≤ `MAX_CHUNK`.
- `dsc_byp_load`, out, 1: descriptor load strobe.
- `busy`, out, 1: high while a command is being issued.
- `grant_id`, out, `$clog2(NUM_REQ)`: index of the current or last granted requester.

## Operation
- The FSM has two states, IDLE and ISSUE.
- **IDLE, arbitration:**
  - Scan `req_valid` round-robin, starting at `last_grant+1` modulo `NUM_REQ`. The first set bit wins (index g).
  - Assert `req_ready[g]` in that cycle, which completes the handshake.
  - Latch `cur_addr <= req_addr[g]`, `remaining <= req_len[g][27:0]`, `grant_id <= g` and `last_grant <= g`.
- **IDLE, zero-length command:** accept it, stay in IDLE and pulse `req_done[g]` on the next cycle. No descriptor is issued.
- **IDLE, nonzero command:** go to ISSUE and set `busy = 1`.
- **ISSUE, descriptor formation:**
  - `off = cur_addr[log2(MAX_CHUNK)-1:0]`
  - `chunk = min(remaining, MAX_CHUNK - off)`
  - `dsc_byp_addr = cur_addr`
  - `dsc_byp_len = chunk`, zero-extended to 32 bits.
- **ISSUE, load:** `dsc_byp_load = (state==ISSUE) & dsc_byp_ready`. It depends on `dsc_byp_ready` combinationally and on nothing else combinationally. On each load:
  - `cur_addr += chunk`, computed in 64 bits with wrap at 2^64.
  - `remaining -= chunk`.
- **ISSUE, last descriptor:** when `chunk == remaining` at a load, the next cycle has:
  - `req_done[grant_id] = 1`
  - `busy = 0`
  - state IDLE, with arbitration active in that same cycle.
- **Stalled input:** `req_valid` is never sampled while in ISSUE. A requester may hold `req_valid` indefinitely without side effects.

## Timing
- **Reset values:**
  - `req_ready`, `req_done`, `dsc_byp_load`, `busy`, `grant_id`, `dsc_byp_addr` and `dsc_byp_len` are all 0.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
- **Acceptance:** accept in cycle T. The first descriptor is valid at T+1, and the earliest load is at T+1.
- **Throughput:** one descriptor per cycle while `dsc_byp_ready` stays high.
- **Completion:** for a command of k descriptors with no stalls, the last load is at T+k and `req_done` plus IDLE occur at T+k+1. The next acceptance can happen at T+k+1.
- **Backpressure:** while `dsc_byp_ready` = 0, `dsc_byp_addr` and `dsc_byp_len` stay stable and `dsc_byp_load` = 0.
- **Reset mid-operation:**
  - `dsc_byp_load`, `req_ready` and `busy` drop immediately, asynchronously.
  - The command in flight is abandoned and no `req_done` is generated.
  - After reset is released, arbitration restarts with priority at requester 0.
- **Address wrap:** an address reaching 2^64 wraps with no error.

## Test plan
- **Aligned split:** req0 with addr=0x1000, len=0x2000, ready held at 1 → loads (0x1000, 0x1000) at T+1 and (0x2000, 0x1000) at T+2; `req_done[0]` at T+3.
- **Unaligned boundary:** req1 with addr=0x0FC0, len=0x100 → loads (0x0FC0, 0x40) then (0x1000, 0xC0); `req_done[1]` once.
- **Round-robin:** all 4 `req_valid` held high, every len=64 → `req_ready` order 0, 1, 2, 3, 0, 1, with exactly one load and one done per grant.
- **Backpressure:** `dsc_byp_ready` toggling 1, 0, 0, 1, … during a 3-chunk command → addr/len stable while ready=0; exactly 3 loads, with correct addresses and lengths.
- **Zero length:** req2 with len=0 accepted at T → `req_done[2]` at T+1, no `dsc_byp_load`, `busy` stays 0.
- **Reset mid-transfer:** assert `pcie_aresetn` low after the 1st of 4 loads → all outputs 0 immediately with no done pulse; after release with req3 and req0 valid, req0 is granted first.

Source files
------------

// File: rtl/dma_desc_scheduler_if.sv
// Command and descriptor-bypass signals shared by the requesters, the
// scheduler and the XDMA C2H descriptor-bypass port.
interface dma_desc_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_len;
  logic [NUM_REQ-1:0]    req_done;
  logic                  dsc_byp_ready;
  logic [63:0]           dsc_byp_addr;
  logic [31:0]           dsc_byp_len;
  logic                  dsc_byp_load;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  modport master (
    input  req_valid, req_addr, req_len, dsc_byp_ready,
    output req_ready, req_done, dsc_byp_addr, dsc_byp_len, dsc_byp_load,
           busy, grant_id
  );

  modport slave (
    output req_valid, req_addr, req_len, dsc_byp_ready,
    input  req_ready, req_done, dsc_byp_addr, dsc_byp_len, dsc_byp_load,
           busy, grant_id
  );
endinterface

// File: rtl/dma_desc_scheduler.sv
// Round-robin sharing of the C2H descriptor-bypass port: each accepted command
// is split into descriptors that never cross a MAX_CHUNK address boundary.
module dma_desc_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_CHUNK = 4096
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_aresetn,
  dma_desc_scheduler_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int OW = $clog2(MAX_CHUNK);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [63:0]        cur_addr_q, cur_addr_d;
  logic [27:0]        remaining_q, remaining_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [NUM_REQ-1:0] req_ready_c;
  logic               found;
  logic [GW-1:0]      pick;
  logic [GW-1:0]      idx;
  logic               accept;
  logic [27:0]        pick_len;
  logic [63:0]        pick_addr;
  logic [OW-1:0]      off;
  logic [28:0]        room;
  logic [27:0]        chunk;
  logic               load;
  logic               last;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_addr = bus.req_addr[{pick, 6'd0} +: 64];
  assign pick_len  = bus.req_len[{pick, 5'd0} +: 28];

  // Gating with the reset pin keeps req_ready low while reset is asserted.
  assign accept = (state_q == IDLE) && found && pcie_aresetn;

  // Room left before the next MAX_CHUNK boundary bounds every descriptor.
  assign off   = cur_addr_q[OW-1:0];
  assign room  = 29'(MAX_CHUNK) - 29'(off);
  assign chunk = ({1'b0, remaining_q} < room) ? remaining_q : room[27:0];
  assign load  = (state_q == ISSUE) && bus.dsc_byp_ready;
  assign last  = (chunk == remaining_q);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    done_d       = '0;
    req_ready_c  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready_c[pick] = 1'b1;
          cur_addr_d        = pick_addr;
          remaining_d       = pick_len;
          grant_id_d        = pick;
          last_grant_d      = pick;
          if (pick_len == '0) begin
            done_d[pick] = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (load) begin
          cur_addr_d  = cur_addr_q + 64'(chunk);
          remaining_d = remaining_q - chunk;
          if (last) begin
            state_d            = IDLE;
            done_d[grant_id_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      done_q       <= done_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.req_done     = done_q;
  assign bus.dsc_byp_addr = cur_addr_q;
  assign bus.dsc_byp_len  = {4'b0, chunk};
  assign bus.dsc_byp_load = load;
  assign bus.busy         = (state_q == ISSUE);
  assign bus.grant_id     = grant_id_q;
endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Bench for dma_desc_scheduler: directed scenarios plus random traffic, all
// checked against a transaction-level queue model of arbitration and splitting.
`timescale 1ns/1ps
module tb_dma_desc_scheduler;
  localparam int NR = 4;
  localparam int MC = 4096;

  logic pcie_clk = 1'b0;
  logic pcie_aresetn = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  dma_desc_scheduler_if #(.NUM_REQ(NR)) bus ();

  dma_desc_scheduler #(.NUM_REQ(NR), .MAX_CHUNK(MC)) dut (
    .pcie_clk    (pcie_clk),
    .pcie_aresetn(pcie_aresetn),
    .bus         (bus)
  );

  logic [63:0] r_addr [NR];
  logic [31:0] r_len  [NR];

  always_comb begin
    bus.req_addr = '0;
    bus.req_len  = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*64 +: 64] = r_addr[i];
      bus.req_len[i*32 +: 32]  = r_len[i];
    end
  end

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Reference model: expected descriptor queue plus arbitration pointer.
  int          m_last = NR - 1;
  int          m_gid  = 0;
  bit          m_busy = 1'b0;
  bit          done_due = 1'b0;
  int          done_id = 0;
  logic [63:0] eq_a [$];
  logic [31:0] eq_l [$];

  int          grants [$];
  int          load_cyc [$];
  logic [63:0] load_a [$];
  logic [31:0] load_l [$];
  int          done_cyc [$];
  int          acc_cyc = 0;
  logic [NR-1:0] acc_mask = '0;
  bit          hold = 1'b0;
  bit          rnd_req = 1'b0;
  int          rdy_mode = 0;
  int          pat = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic split(input logic [63:0] a, input logic [27:0] r);
    longint unsigned rem, room, c;
    rem = 64'(r);
    while (rem != 0) begin
      room = 64'(MC) - (a % 64'(MC));
      c = (rem < room) ? rem : room;
      eq_a.push_back(a);
      eq_l.push_back(32'(c));
      a = a + c;
      rem = rem - c;
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; done_due = 1'b0; m_last = NR - 1; m_gid = 0;
    eq_a.delete(); eq_l.delete(); acc_mask = '0;
  endtask

  task automatic clear_logs();
    grants.delete(); load_cyc.delete(); load_a.delete(); load_l.delete(); done_cyc.delete();
  endtask

  task automatic monitor();
    bit cur_busy;
    int pick;
    logic [NR-1:0] exp_rdy;
    if (!pcie_aresetn) return;
    cur_busy = m_busy;
    chk("req_done", 64'(bus.req_done), done_due ? (64'(1) << done_id) : 64'(0));
    if (bus.req_done != '0) done_cyc.push_back(cyc);
    done_due = 1'b0;
    chk("busy", 64'(bus.busy), 64'(cur_busy));
    chk("grant_id", 64'(bus.grant_id), 64'(m_gid));
    chk("dsc_load", 64'(bus.dsc_byp_load), 64'(cur_busy && bus.dsc_byp_ready));
    if (bus.dsc_byp_load) begin
      load_cyc.push_back(cyc); load_a.push_back(bus.dsc_byp_addr); load_l.push_back(bus.dsc_byp_len);
    end
    if (cur_busy) begin
      chk("ready_while_busy", 64'(bus.req_ready), 64'(0));
      if (eq_a.size() == 0) begin
        chk("model_queue_empty", 64'(1), 64'(0));
        m_busy = 1'b0;
      end else begin
        chk("dsc_addr", bus.dsc_byp_addr, eq_a[0]);
        chk("dsc_len", 64'(bus.dsc_byp_len), 64'(eq_l[0]));
        if (bus.dsc_byp_ready) begin
          void'(eq_a.pop_front());
          void'(eq_l.pop_front());
          if (eq_a.size() == 0) begin
            m_busy = 1'b0; done_due = 1'b1; done_id = m_gid;
          end
        end
      end
    end else begin
      pick = -1;
      for (int k = 1; k <= NR; k++)
        if (pick < 0 && bus.req_valid[(m_last + k) % NR]) pick = (m_last + k) % NR;
      exp_rdy = (pick < 0) ? '0 : (NR'(1) << pick);
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (pick >= 0) begin
        split(r_addr[pick], r_len[pick][27:0]);
        m_last = pick; m_gid = pick; acc_cyc = cyc;
        grants.push_back(pick);
        acc_mask[pick] = 1'b1;
        if (eq_a.size() == 0) begin
          done_due = 1'b1; done_id = pick;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  endtask

  task automatic new_cmd(input int i);
    if ($urandom_range(7) == 0) r_addr[i] = {32'hFFFF_FFFF, 20'hFFFFF, 12'($urandom)};
    else r_addr[i] = {$urandom, $urandom};
    if ($urandom_range(7) == 0) r_len[i] = {4'($urandom), 28'd0};
    else r_len[i] = {4'($urandom), 28'($urandom_range(3 * MC + 300, 1))};
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic tick();
    @(negedge pcie_clk);
    monitor();
    @(posedge pcie_clk);
    cyc++;
    #2;
    for (int i = 0; i < NR; i++)
      if (acc_mask[i] && !hold) bus.req_valid[i] = 1'b0;
    acc_mask = '0;
    if (rnd_req)
      for (int i = 0; i < NR; i++)
        if (!bus.req_valid[i] && $urandom_range(3) == 0) new_cmd(i);
    if (rdy_mode == 1) begin
      bus.dsc_byp_ready = (pat % 3 == 0);
      pat++;
    end else if (rdy_mode == 2) begin
      bus.dsc_byp_ready = ($urandom_range(9) < 7);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || done_due || bus.req_valid != '0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(1), 64'(0));
    tick();
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    chk({t, "_req_done"}, 64'(bus.req_done), 64'(0));
    chk({t, "_load"}, 64'(bus.dsc_byp_load), 64'(0));
    chk({t, "_busy"}, 64'(bus.busy), 64'(0));
    chk({t, "_grant_id"}, 64'(bus.grant_id), 64'(0));
    chk({t, "_dsc_addr"}, bus.dsc_byp_addr, 64'(0));
    chk({t, "_dsc_len"}, 64'(bus.dsc_byp_len), 64'(0));
  endtask

  initial begin
    int n;
    int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
    bus.req_valid = '0;
    bus.dsc_byp_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin r_addr[i] = '0; r_len[i] = '0; end
    #12;
    check_reset_outputs("rst");
    @(posedge pcie_clk); #2;
    pcie_aresetn = 1'b1;

    // Round-robin with all requesters held valid
    clear_logs();
    bus.dsc_byp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin r_addr[i] = 64'h1_0000 + 64'(i * 64); r_len[i] = 32'd64; end
    hold = 1'b1;
    bus.req_valid = '1;
    n = 0;
    while (grants.size() < 6 && n < 100) begin tick(); n++; end
    hold = 1'b0;
    bus.req_valid = '0;
    drain();
    chk("rr_grants", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_order", 64'(grants[i]), 64'(exp_rr[i]));
    chk("rr_loads", 64'(load_a.size()), 64'(6));
    chk("rr_dones", 64'(done_cyc.size()), 64'(6));

    // Aligned split
    clear_logs();
    r_addr[0] = 64'h1000; r_len[0] = 32'h2000; bus.req_valid[0] = 1'b1;
    drain();
    chk("al_nload", 64'(load_a.size()), 64'(2));
    if (load_a.size() == 2 && done_cyc.size() == 1) begin
      chk("al_a0", load_a[0], 64'h1000);  chk("al_l0", 64'(load_l[0]), 64'h1000);
      chk("al_a1", load_a[1], 64'h2000);  chk("al_l1", 64'(load_l[1]), 64'h1000);
      chk("al_t1", 64'(load_cyc[0]), 64'(acc_cyc + 1));
      chk("al_t2", 64'(load_cyc[1]), 64'(acc_cyc + 2));
      chk("al_done_t", 64'(done_cyc[0]), 64'(acc_cyc + 3));
    end

    // Unaligned boundary
    clear_logs();
    r_addr[1] = 64'h0FC0; r_len[1] = 32'h100; bus.req_valid[1] = 1'b1;
    drain();
    chk("ua_nload", 64'(load_a.size()), 64'(2));
    chk("ua_ndone", 64'(done_cyc.size()), 64'(1));
    if (load_a.size() == 2) begin
      chk("ua_a0", load_a[0], 64'h0FC0); chk("ua_l0", 64'(load_l[0]), 64'h40);
      chk("ua_a1", load_a[1], 64'h1000); chk("ua_l1", 64'(load_l[1]), 64'hC0);
    end

    // Backpressure during a 3-chunk command
    clear_logs();
    pat = 0; rdy_mode = 1;
    r_addr[2] = 64'h3800; r_len[2] = 32'h2000; bus.req_valid[2] = 1'b1;
    drain();
    rdy_mode = 0; bus.dsc_byp_ready = 1'b1;
    chk("bp_nload", 64'(load_a.size()), 64'(3));
    chk("bp_ndone", 64'(done_cyc.size()), 64'(1));

    // Zero-length command
    clear_logs();
    r_addr[2] = 64'h5000; r_len[2] = 32'h0; bus.req_valid[2] = 1'b1;
    drain();
    chk("zl_nload", 64'(load_a.size()), 64'(0));
    chk("zl_ndone", 64'(done_cyc.size()), 64'(1));
    if (done_cyc.size() == 1) chk("zl_done_t", 64'(done_cyc[0]), 64'(acc_cyc + 1));

    // Reset after the first of four loads
    clear_logs();
    r_addr[0] = 64'h1_0000; r_len[0] = 32'h4000; bus.req_valid[0] = 1'b1;
    n = 0;
    while (load_a.size() < 1 && n < 20) begin tick(); n++; end
    pcie_aresetn = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    r_addr[0] = 64'h2_0000; r_len[0] = 32'd64;
    r_addr[3] = 64'h3_0000; r_len[3] = 32'd64;
    bus.req_valid[0] = 1'b1; bus.req_valid[3] = 1'b1;
    tick(); tick();
    chk("mid_no_done", 64'(done_cyc.size()), 64'(0));
    pcie_aresetn = 1'b1;
    grants.delete();
    drain();
    chk("mid_ngrant", 64'(grants.size()), 64'(2));
    if (grants.size() == 2) begin
      chk("mid_first", 64'(grants[0]), 64'(0));
      chk("mid_second", 64'(grants[1]), 64'(3));
    end
    chk("mid_nload", 64'(load_a.size()), 64'(3));
    chk("mid_ndone", 64'(done_cyc.size()), 64'(2));

    // Random traffic with random backpressure, including wrap near 2^64
    clear_logs();
    rnd_req = 1'b1; rdy_mode = 2;
    repeat (3000) tick();
    rnd_req = 1'b0; rdy_mode = 0; bus.dsc_byp_ready = 1'b1;
    drain();
    chk("rnd_grant_done", 64'(done_cyc.size()), 64'(grants.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
